// File: rtl/uart_tx_fifo.sv
// Buffered 8-bit UART transmitter: power-of-two byte FIFO feeding a start/8-data/stop serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_en,
    input  logic [7:0] write_data,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overrun
);

    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: baud divisor must be at least 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..256");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          push, pop;
    logic [7:0]    head;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (cnt_q == DIV_M1);
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

    // A pop happens on leaving IDLE or at the last stop-bit cycle, so frames chain with no gap.
    always_comb begin
        push      = write_en && !full;
        pop       = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && bit_end));
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (write_en && full)  overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_q + 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (pop) begin
                        shift_q <= head;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^head;
`endif
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= par_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shift_q <= head;
`ifdef UART_TX_PARITY_EN
                            par_q   <= ^head;
`endif
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
